pipeline_ctrl: RTL and testbench



---
 rtl/lc3b_types.sv | 11 +
 rtl/mem_port_tracker.sv | 19 +
 rtl/pipeline_ctrl.sv | 69 ++++++
 tb/tb_pipeline_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath and control types
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic {WAIT, DONE} lc3b_port_state;
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
    } lc3b_control;
endpackage

// File: rtl/mem_port_tracker.sv
// mem_port_tracker: remembers a cache response until the pipeline advances
module mem_port_tracker
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic resp,
    input  logic adv,
    output logic done_q,
    output logic ok
);
    lc3b_port_state state;
    always_ff @(posedge clk) begin
        if (reset || adv) state <= WAIT;
        else if (resp) state <= DONE;
    end
    assign done_q = state == DONE;
    assign ok = resp | done_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/advance sequencing, valid bits, bubbles and flushes
module pipeline_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             icache_resp,
    output logic             icache_read,
    input  logic             dmem_rd_req,
    input  logic             dmem_wr_req,
    input  logic             dcache_resp,
    output logic             dcache_read,
    output logic             dcache_write,
    input  logic             load_use,
    input  logic             br_taken,
    output logic             pc_sel_target,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [CNT_W-1:0] stall_count
);
    logic i_done, i_ok, d_done, d_ok, d_need, adv, flush, bubble;
    mem_port_tracker u_i (
        .clk, .reset, .resp(icache_resp), .adv, .done_q(i_done), .ok(i_ok)
    );
    mem_port_tracker u_d (
        .clk, .reset, .resp(dcache_resp), .adv, .done_q(d_done), .ok(d_ok)
    );
    always_comb begin
        d_need        = mem_valid & (dmem_rd_req | dmem_wr_req);
        icache_read   = !i_done;
        dcache_write  = d_need & !d_done & dmem_wr_req;
        dcache_read   = d_need & !d_done & dmem_rd_req & !dmem_wr_req;
        adv           = i_ok & (!d_need | d_ok) & !reset;
        flush         = adv & mem_valid & br_taken;
        bubble        = adv & load_use & id_valid & !flush;
        mem_wb_load   = adv;
        ex_mem_load   = adv;
        id_ex_load    = adv;
        pc_load       = adv & !bubble;
        if_id_load    = adv & !bubble;
        pc_sel_target = flush;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid    <= 1'b0;
            ex_valid    <= 1'b0;
            mem_valid   <= 1'b0;
            wb_valid    <= 1'b0;
            stall_count <= '0;
        end else begin
            if (adv) begin
                wb_valid  <= mem_valid;
                mem_valid <= ex_valid & !flush;
                ex_valid  <= id_valid & !flush & !bubble;
                id_valid  <= bubble ? id_valid : !flush;
            end
            if (!adv && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of advance, stall, bubble, flush and counter
module tb_pipeline_ctrl;
    logic clk = 0, reset = 1;
    logic icache_resp = 0, dmem_rd_req = 0, dmem_wr_req = 0, dcache_resp = 0;
    logic load_use = 0, br_taken = 0;
    logic icache_read, dcache_read, dcache_write, pc_sel_target;
    logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic id_valid, ex_valid, mem_valid, wb_valid;
    logic [15:0] stall_count;
    int n_tests = 0, n_fail = 0;

    pipeline_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .icache_resp(icache_resp), .icache_read(icache_read),
        .dmem_rd_req(dmem_rd_req), .dmem_wr_req(dmem_wr_req), .dcache_resp(dcache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write), .load_use(load_use),
        .br_taken(br_taken), .pc_sel_target(pc_sel_target), .pc_load(pc_load),
        .if_id_load(if_id_load), .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
        .mem_wb_load(mem_wb_load), .id_valid(id_valid), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] valids;
        return {id_valid, ex_valid, mem_valid, wb_valid};
    endfunction

    initial begin
        icache_resp = 1;
        #1;
        check("reset_pc_load", pc_load, 0);
        check("reset_mem_wb_load", mem_wb_load, 0);
        tick;
        tick;
        reset = 0;
        icache_resp = 0;
        #1;
        check("post_reset_valids", valids(), 4'b0000);
        check("post_reset_stall", stall_count, 0);
        check("post_reset_icache_read", icache_read, 1);
        tick;
        // fill: no D access, fetch completes each cycle
        icache_resp = 1;
        #1;
        check("fill_pc_load", pc_load, 1);
        tick;
        check("fill_v1", valids(), 4'b1000);
        check("fill_pc_load2", pc_load, 1);
        tick;
        check("fill_v2", valids(), 4'b1100);
        tick;
        check("fill_v3", valids(), 4'b1110);
        tick;
        check("fill_v4", valids(), 4'b1111);
        check("fill_stall", stall_count, 1);
        // load in MEM: I completes in cycle 2, D in cycle 5
        icache_resp = 0;
        dmem_rd_req = 1;
        #1;
        check("ld_c1_dread", dcache_read, 1);
        check("ld_c1_pc_load", pc_load, 0);
        tick;
        icache_resp = 1;
        #1;
        check("ld_c2_pc_load", pc_load, 0);
        tick;
        icache_resp = 0;
        #1;
        check("ld_c3_iread", icache_read, 0);
        tick;
        check("ld_c4_iread", icache_read, 0);
        tick;
        dcache_resp = 1;
        #1;
        check("ld_c5_iread", icache_read, 0);
        check("ld_c5_pc_load", pc_load, 1);
        tick;
        dcache_resp = 0;
        dmem_rd_req = 0;
        check("ld_stall", stall_count, 5);
        check("ld_iread_again", icache_read, 1);
        check("ld_valids", valids(), 4'b1111);
        // load-use bubble
        icache_resp = 1;
        load_use = 1;
        #1;
        check("lu_pc_load", pc_load, 0);
        check("lu_if_id_load", if_id_load, 0);
        check("lu_id_ex_load", id_ex_load, 1);
        tick;
        load_use = 0;
        check("lu_valids", valids(), 4'b1011);
        tick;
        check("lu_v2", valids(), 4'b1101);
        tick;
        tick;
        check("lu_v4", valids(), 4'b1111);
        // taken branch beats load-use
        br_taken = 1;
        load_use = 1;
        #1;
        check("br_sel", pc_sel_target, 1);
        check("br_pc_load", pc_load, 1);
        check("br_if_id_load", if_id_load, 1);
        tick;
        br_taken = 0;
        load_use = 0;
        check("br_valids", valids(), 4'b0001);
        check("br_sel_off", pc_sel_target, 0);
        // both D requests with mem_valid=0: no request, I alone advances
        dmem_rd_req = 1;
        dmem_wr_req = 1;
        #1;
        check("nomv_dwrite", dcache_write, 0);
        check("nomv_dread", dcache_read, 0);
        check("nomv_pc_load", pc_load, 1);
        dmem_rd_req = 0;
        dmem_wr_req = 0;
        tick;
        tick;
        tick;
        check("st_fill", valids(), 4'b1110);
        icache_resp = 0;
        dmem_rd_req = 1;
        dmem_wr_req = 1;
        #1;
        check("st_dwrite", dcache_write, 1);
        check("st_dread", dcache_read, 0);
        tick;
        icache_resp = 1;
        dcache_resp = 1;
        #1;
        check("st_pc_load", pc_load, 1);
        tick;
        dcache_resp = 0;
        dmem_rd_req = 0;
        dmem_wr_req = 0;
        check("st_stall", stall_count, 6);
        // saturation
        icache_resp = 0;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_count", stall_count, 16'hFFFF);
        tick;
        tick;
        check("sat_hold", stall_count, 16'hFFFF);
        check("sat_iread", icache_read, 1);
        reset = 1;
        icache_resp = 1;
        #1;
        check("rst_pc_load", pc_load, 0);
        tick;
        reset = 0;
        icache_resp = 0;
        check("rst_valids", valids(), 4'b0000);
        check("rst_stall", stall_count, 0);
        check("rst_iread", icache_read, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
